uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the UART IP: recovers 8N1 (optionally 8E1) frames from the asynchronous `rx` line, using the per-bit clock count from `uart_baud_rate_generator`'s `clks_per_bit_rx` output. Received bytes go to the consumer over a valid/ready handshake, with single-entry buffering. The block also reports framing and overrun errors, and parity errors when parity is enabled. It sits between the pad-side `rx` pin and the UART register/FIFO logic.

## Interface
- `RX_CNT_WIDTH`, 9: width of `clks_per_bit_rx`. Must match the generator's `RX_CNT_WIDTH`.
- `DATA_BITS`, 8: data bits per frame, sent LSB first. Legal range is 5–8.
- `clk` input 1: single system clock. All logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clks_per_bit_rx` input RX_CNT_WIDTH: `clk` cycles per bit (N). Minimum legal value is 4.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` output DATA_BITS: received byte, valid while `rx_valid`=1.
- `rx_valid` output 1: a byte is held and waiting to be accepted.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `busy` output 1: high in any state other than IDLE.
- `frame_err` output 1: one-cycle pulse; the stop bit was sampled as 0.
- `parity_err` output 1: one-cycle pulse; parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.
- `overrun` output 1: one-cycle pulse; a good byte completed while the buffer was still full.

## Operation
- **Synchronizer:** 2-FF synchronizer on `rx`, both flops reset to 1. A third flop `rx_prev` holds the previous synchronized value for edge detection.
- **Latching N:** N is latched from `clks_per_bit_rx` at start-bit detection. Changes to the input during a frame are ignored.
- **Counter:** `bit_cnt` is RX_CNT_WIDTH wide; its terminal value is state dependent. `bit_idx` is 3 bits.
- **IDLE:** on a synchronized 1→0 edge, clear `bit_cnt` and go to START. A line held low, such as a break, does not retrigger the receiver.
- **START:** count 0..(N>>1)−1, then sample the line.
  - If 0, go to DATA with `bit_cnt`=0 and `bit_idx`=0.
  - If 1, the start bit was a glitch: go to IDLE with no flag.
- **DATA:** count 0..N−1. At the terminal count, sample the line and shift it into bit position `bit_idx` (LSB first).
  - After bit DATA_BITS−1, go to PARITY if enabled, otherwise to STOP.
- **PARITY** (macro only): count 0..N−1, then sample. Parity is even: the XOR of the data bits and the parity bit must be 0. Record a mismatch, then go to STOP.
- **STOP:** count 0..N−1, then sample and return to IDLE.
  - **Sample = 0:** pulse `frame_err`. The byte is discarded and the buffer is untouched.
  - **Parity mismatch:** pulse `parity_err`. The byte is discarded.
  - **Good frame, buffer free or being accepted this cycle:** load `rx_data` and set `rx_valid`.
  - **Good frame, buffer full and not accepted this cycle:** pulse `overrun`. The new byte is dropped and the held byte is kept.
- **Precedence:** `frame_err` takes precedence over `parity_err`. Only one error pulse fires per frame.
- **Handshake:** `rx_valid` clears on the cycle after `rx_valid && rx_ready`. Load and accept in the same cycle gives `rx_valid`=1 with the new data.
- `rx_data` is stable while `rx_valid`=1.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. FSM in IDLE, counters 0.
- **Input latency:** 2 `clk` cycles from the `rx` pin to the synchronized value. Edge detection adds 1 more cycle.
- **Sample points:** each sample is taken mid-bit. The start sample is (N>>1) cycles after entering START. Every later sample is N cycles after the previous one.
- **Output timing:** `rx_valid`, `frame_err`, `parity_err` and `overrun` are registered. They appear 1 cycle after the stop-bit sample edge.
- **Frame length:** the stop sample falls (N>>1) + (DATA_BITS+P+1)·N cycles after entering START, where P=1 with parity and 0 without.
- **Next frame:** a new start edge is accepted from the cycle after the return to IDLE. Back-to-back frames with a full stop bit are received without loss.
- **Reset mid-frame:** asserting `rst_n` low in any state immediately restores all reset values. The partial frame is discarded and any held byte is lost.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is compiled in, the frame is start, DATA_BITS data, even parity, stop, and `parity_err` is live.
- Macro undefined: there is no PARITY state, the frame is start, DATA_BITS data, stop, and `parity_err` is tied to 0.

## Test plan
- **Nominal receive:** N=86 (10 MHz, 115200), `rx_ready`=1, send 0xA5 → `rx_data`=0xA5 with a one-cycle `rx_valid`, no error flags. Repeat with N=1041 (9600) sending 0x5A.
- **Glitch rejection:** N=86, drive `rx` low for 20 cycles then high → FSM returns to IDLE, no `rx_valid`, no flags.
- **Framing error:** N=86, send 0x3C with stop bit 0 → one-cycle `frame_err`, `rx_valid` stays 0. Hold `rx` low for 2000 cycles → no further frames. Return `rx` high, send 0x11 → received correctly.
- **Overrun and handshake:** `rx_ready`=0, send 0x3C then 0xC3 back-to-back → `rx_data`=0x3C held and one `overrun` pulse. Raise `rx_ready` → `rx_valid` drops the next cycle.
- **Parity** (macro defined): send 0x01 with parity bit 0 → `parity_err` pulse, no `rx_valid`. Send 0x01 with parity bit 1 → `rx_data`=0x01.
- **Reset mid-frame:** pulse `rst_n` low during data bit 3 → all outputs read 0 and `busy`=0. The next frame, 0x7E, is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver (8N1 by default, 8E1 with UART_RX_PARITY_EN).
//
// Recovers serial frames from the asynchronous rx line. The bit period is
// taken from clks_per_bit_rx (N clk cycles per bit) and latched when the
// start edge is detected. Each bit is sampled at its middle. Received bytes
// are offered through a single-entry valid/ready buffer.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : frame is start, DATA_BITS data, even parity, stop.
//   undefined : frame is start, DATA_BITS data, stop; parity_err tied to 0.
//
// Ports:
//   clk             in   system clock, all logic on its rising edge
//   rst_n           in   asynchronous active-low reset
//   clks_per_bit_rx in   clk cycles per bit (N), minimum 4
//   rx              in   serial line, idle high, asynchronous to clk
//   rx_data         out  received byte, valid while rx_valid is 1
//   rx_valid        out  a byte is held and waiting to be accepted
//   rx_ready        in   consumer accepts the byte when rx_valid && rx_ready
//   busy            out  receiver is inside a frame (state other than IDLE)
//   frame_err       out  one-cycle pulse: stop bit sampled as 0
//   parity_err      out  one-cycle pulse: even-parity mismatch
//   overrun         out  one-cycle pulse: good byte dropped, buffer full
//
// Handshake: rx_valid rises when a byte is loaded and stays high, with
// rx_data held stable, until a cycle in which rx_valid && rx_ready; it clears
// on the following cycle unless a new byte is loaded in that same cycle.

module uart_rx #(
    parameter int RX_CNT_WIDTH = 9,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RX_CNT_WIDTH-1:0] clks_per_bit_rx,
    input  logic                    rx,
    output logic [DATA_BITS-1:0]    rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    overrun
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    localparam logic [2:0]              LAST_IDX = 3'(DATA_BITS - 1);
    localparam logic [RX_CNT_WIDTH-1:0] CNT_ONE  = RX_CNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    rx_meta, rx_sync, rx_prev;
    logic [RX_CNT_WIDTH-1:0] n_q, n_d;
    logic [RX_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    load;
    logic                    fe_d, pe_d, ov_d;
    logic                    start_edge;
    logic                    half_done, bit_done;
`ifdef UART_RX_PARITY_EN
    logic                    par_bad_q, par_bad_d;
`endif

    // Only a 1->0 transition starts a frame, so a line held low (break or
    // stuck-low after a framing error) never retriggers the receiver.
    assign start_edge = rx_prev & ~rx_sync;
    assign half_done  = (cnt_q == ((n_q >> 1) - CNT_ONE));
    assign bit_done   = (cnt_q == (n_q - CNT_ONE));
    assign busy       = (state_q != S_IDLE);

    // Two-flop synchronizer plus edge-detect history, all idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        load    = 1'b0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = S_START;
                    n_d     = clks_per_bit_rx;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (half_done) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    // Even parity: data bits XOR parity bit must be 0.
                    par_bad_d = (^shift_q) ^ rx_sync;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_sync) begin
                        fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        pe_d = 1'b1;
`endif
                    end else if (rx_valid && !rx_ready) begin
                        ov_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            frame_err  <= fe_d;
            parity_err <= pe_d;
            overrun    <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
            // Load wins over the accept clear, so a load during an accept
            // leaves rx_valid high with the new byte.
            if (load) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Frames are driven at the pin level; a frame-level model decides, from the
// line protocol rules alone, which bytes must reach the consumer and which
// error pulses must appear. A negedge monitor records what the DUT delivers.

`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CW = 11;
    localparam int DB = 8;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] clks_per_bit_rx;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          busy;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    uart_rx #(.RX_CNT_WIDTH(CW), .DATA_BITS(DB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clks_per_bit_rx (clks_per_bit_rx),
        .rx              (rx),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .busy            (busy),
        .frame_err       (frame_err),
        .parity_err      (parity_err),
        .overrun         (overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fails  = 0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] act_q[$];
    int            rd_ptr    = 0;
    int            exp_fe    = 0;
    int            exp_pe    = 0;
    int            exp_ov    = 0;
    bit            model_full = 1'b0;

    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    int valid_cycles = 0;

    // Monitor: a byte counts as delivered when valid and ready meet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) act_q.push_back(rx_data);
            if (rx_valid)   valid_cycles <= valid_cycles + 1;
            if (frame_err)  fe_cnt <= fe_cnt + 1;
            if (parity_err) pe_cnt <= pe_cnt + 1;
            if (overrun)    ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare delivered bytes and error pulse totals against the model.
    task automatic check_all(input string tag);
        int pending;
        pending = act_q.size() - rd_ptr;
        check({tag, "_count"}, 32'(pending), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rd_ptr < act_q.size()) begin
            check({tag, "_data"}, 32'(act_q[rd_ptr]), 32'(exp_q.pop_front()));
            rd_ptr++;
        end
        exp_q.delete();
        rd_ptr = act_q.size();
        check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_parity_err"}, 32'(pe_cnt), 32'(exp_pe));
        check({tag, "_overrun"}, 32'(ov_cnt), 32'(exp_ov));
    endtask

    // Frame-level model: outcome of one frame given the consumer state.
    task automatic model_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v);
        logic par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = (((^d) ^ par_v) == 1'b0);
`else
        par_ok = 1'b1;
        if (par_v === 1'bx) par_ok = 1'b1;
`endif
        if (!stop_v) exp_fe++;
        else if (!par_ok) exp_pe++;
        else if (model_full && !rx_ready) exp_ov++;
        else begin
            exp_q.push_back(d);
            model_full = !rx_ready;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        tick(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v,
                              input int n, input bit scramble);
        clks_per_bit_rx = CW'(n);
        drive_bit(1'b0, n);
        // The receiver must keep using the bit period latched at the start edge.
        if (scramble) clks_per_bit_rx = CW'($urandom_range(4, 2000));
        for (int i = 0; i < DB; i++) drive_bit(d[i], n);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v, n);
`endif
        drive_bit(stop_v, n);
        rx = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DB-1:0] d;
        logic          sv;
        logic          pv;
        int            n;
        int            gap;
        int            vc0;

        rst_n           = 1'b0;
        rx              = 1'b1;
        rx_ready        = 1'b1;
        clks_per_bit_rx = CW'(86);
        tick(3);

        // Reset values.
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Nominal receive at 115200 from 10 MHz.
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, ^8'hA5, 86, 1'b0);
        model_frame(8'hA5, 1'b1, ^8'hA5);
        tick(4);
        check("nom86_valid_len", 32'(valid_cycles - vc0), 32'd1);
        check_all("nom86");

        // Nominal receive at 9600.
        vc0 = valid_cycles;
        send_frame(8'h5A, 1'b1, ^8'h5A, 1041, 1'b0);
        model_frame(8'h5A, 1'b1, ^8'h5A);
        tick(4);
        check("nom1041_valid_len", 32'(valid_cycles - vc0), 32'd1);
        check_all("nom1041");

        // Glitch rejection.
        clks_per_bit_rx = CW'(86);
        rx = 1'b0;
        tick(10);
        check("glitch_busy_mid", 32'(busy), 32'd1);
        tick(10);
        rx = 1'b1;
        tick(86);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check_all("glitch");

        // Framing error, then line stuck low, then recovery.
        send_frame(8'h3C, 1'b0, ^8'h3C, 86, 1'b0);
        rx = 1'b0;
        model_frame(8'h3C, 1'b0, ^8'h3C);
        tick(2000);
        check("break_busy", 32'(busy), 32'd0);
        check_all("frame_err");
        rx = 1'b1;
        tick(10);
        send_frame(8'h11, 1'b1, ^8'h11, 86, 1'b0);
        model_frame(8'h11, 1'b1, ^8'h11);
        tick(4);
        check_all("recover");

        // Overrun with the consumer stalled, then release.
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, ^8'h3C, 86, 1'b0);
        model_frame(8'h3C, 1'b1, ^8'h3C);
        send_frame(8'hC3, 1'b1, ^8'hC3, 86, 1'b0);
        model_frame(8'hC3, 1'b1, ^8'hC3);
        tick(4);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_held", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        model_full = 1'b0;
        tick(1);
        check("ovr_valid_drop", 32'(rx_valid), 32'd0);
        check_all("overrun");

`ifdef UART_RX_PARITY_EN
        // Parity error, then correct parity.
        send_frame(8'h01, 1'b1, 1'b0, 86, 1'b0);
        model_frame(8'h01, 1'b1, 1'b0);
        tick(4);
        check("par_bad_valid", 32'(rx_valid), 32'd0);
        check_all("par_bad");
        send_frame(8'h01, 1'b1, 1'b1, 86, 1'b0);
        model_frame(8'h01, 1'b1, 1'b1);
        tick(4);
        check_all("par_good");
`endif

        // Reset mid-frame discards both the partial frame and a held byte.
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b1, ^8'h55, 86, 1'b0);
        tick(4);
        check("mid_held_valid", 32'(rx_valid), 32'd1);
        check("mid_held_data", 32'(rx_data), 32'h55);
        d = 8'h7E;
        drive_bit(1'b0, 86);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 86);
        rx = d[3];
        tick(43);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_data", 32'(rx_data), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_flags", 32'({frame_err, parity_err, overrun}), 32'h0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        model_full = 1'b0;
        tick(10);
        send_frame(8'h7E, 1'b1, ^8'h7E, 86, 1'b0);
        model_frame(8'h7E, 1'b1, ^8'h7E);
        tick(4);
        check_all("after_rst");

        // Random frames: random bit period, data, stop and parity faults,
        // inter-frame gaps, and a disturbed period input mid-frame.
        for (int f = 0; f < 16; f++) begin
            n   = $urandom_range(8, 40);
            d   = DB'($urandom_range(0, 255));
            sv  = ($urandom_range(0, 5) != 0);
            pv  = (^d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, sv, pv, n, 1'b1);
            model_frame(d, sv, pv);
            gap = sv ? $urandom_range(0, n) : $urandom_range(2, n);
            if (gap > 0) tick(gap);
        end
        tick(50);
        check("rand_busy_end", 32'(busy), 32'd0);
        check_all("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
